// File: rtl/request_agent.sv
// request_agent: client-side job source for the round-robin arbiter.
// Tracks pending jobs per client, requests service, retires on grant.
module request_agent #(
  parameter int width = 5,
  parameter int time_quantum = 2,
  parameter int count_width = 4,
  localparam int idx_w = (width > 1) ? $clog2(width) : 1
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_push_valid,
  input  logic [idx_w-1:0] in_push_id,
  output logic             out_push_ready,
  output logic [width-1:0] out_request,
  input  logic [width-1:0] in_grant,
  output logic             out_active_valid,
  output logic [idx_w-1:0] out_active_id,
  output logic             out_done,
  output logic [idx_w-1:0] out_done_id,
  output logic             out_preempt,
  output logic             out_grant_error
);

  localparam int sw = $clog2(time_quantum + 1);
  localparam logic [count_width-1:0] cmax = '1;

  typedef enum logic {
    st_idle,
    st_serve
  } state_t;

  state_t state, state_n;

  logic [count_width-1:0] pending [width];
  logic [sw-1:0]    svc, svc_n;
  logic [idx_w-1:0] aid, aid_n;
  logic [idx_w-1:0] push_idx;
  logic             id_ok;
  logic             push_ok;
  logic             multi, stray, err, onehot;
  logic [idx_w-1:0] gid;
  logic [width-1:0] act_mask;
  logic             retire;
  logic [idx_w-1:0] rid;
  logic             preempt_n;

  // Push acceptance: in-range client whose counter is not full.
  always_comb begin
    id_ok = int'(in_push_id) < width;
    push_idx = id_ok ? in_push_id : '0;
    out_push_ready = id_ok && (pending[push_idx] != cmax);
    push_ok = in_push_valid && out_push_ready;
  end

  // Request vector is a pure decode of the counters.
  always_comb begin
    for (int i = 0; i < width; i++)
      out_request[i] = |pending[i];
  end

  // Classify the grant: error, clean one-hot, and its index.
  always_comb begin
    multi = $countones(in_grant) > 1;
    stray = |(in_grant & ~out_request);
    err = multi || stray;
    onehot = (in_grant != '0) && !err;
    gid = '0;
    for (int i = 0; i < width; i++)
      if (in_grant[i]) gid = idx_w'(i);
    act_mask = width'(1) << aid;
  end

  // Next-state and service bookkeeping.
  always_comb begin
    state_n = state;
    svc_n = svc;
    aid_n = aid;
    retire = 1'b0;
    rid = aid;
    preempt_n = 1'b0;
    unique case (state)
      st_idle: begin
        if (onehot) begin
          if (time_quantum == 1) begin
            retire = 1'b1;
            rid = gid;
          end else begin
            state_n = st_serve;
            aid_n = gid;
            svc_n = sw'(1);
          end
        end
      end
      st_serve: begin
        if (!err && in_grant == act_mask) begin
          if (int'(svc) + 1 >= time_quantum) begin
            retire = 1'b1;
            state_n = st_idle;
            svc_n = '0;
            aid_n = '0;
          end else begin
            svc_n = svc + sw'(1);
          end
        end else begin
          preempt_n = 1'b1;
          state_n = st_idle;
          svc_n = '0;
          aid_n = '0;
        end
      end
      default: begin
        state_n = st_idle;
      end
    endcase
  end

  // FSM, service counter and registered status outputs.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state <= st_idle;
      svc <= '0;
      aid <= '0;
      out_active_valid <= 1'b0;
      out_done <= 1'b0;
      out_done_id <= '0;
      out_preempt <= 1'b0;
      out_grant_error <= 1'b0;
    end else begin
      state <= state_n;
      svc <= svc_n;
      aid <= aid_n;
      out_active_valid <= (state_n == st_serve);
      out_done <= retire;
      if (retire) out_done_id <= rid;
      out_preempt <= preempt_n;
      if (err) out_grant_error <= 1'b1;
    end
  end

  assign out_active_id = aid;

  // Pending counters: push adds, retire subtracts, both cancel.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      for (int i = 0; i < width; i++)
        pending[i] <= '0;
    end else begin
      for (int i = 0; i < width; i++) begin
        if (push_ok && push_idx == idx_w'(i) &&
            !(retire && rid == idx_w'(i)))
          pending[i] <= pending[i] + 1'b1;
        else if (retire && rid == idx_w'(i) &&
                 !(push_ok && push_idx == idx_w'(i)))
          pending[i] <= pending[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_request_agent.sv
// tb_request_agent: directed checks of request_agent.
// Main instance uses defaults; a second uses 2-bit counters.
module tb_request_agent;

  logic       clk;
  logic       rst;
  logic       pv;
  logic [2:0] pid;
  logic [4:0] gnt;
  logic       ready;
  logic [4:0] req;
  logic       act;
  logic [2:0] act_id;
  logic       done;
  logic [2:0] done_id;
  logic       pre;
  logic       gerr;

  logic       s_pv;
  logic [2:0] s_pid;
  logic [4:0] s_gnt;
  logic       s_ready;
  logic [4:0] s_req;
  logic       s_act;
  logic [2:0] s_act_id;
  logic       s_done;
  logic [2:0] s_done_id;
  logic       s_pre;
  logic       s_gerr;

  int checks = 0;
  int errors = 0;

  request_agent #(
    .width(5), .time_quantum(2), .count_width(4)
  ) u_dut (
    .in_clk(clk), .in_reset(rst),
    .in_push_valid(pv), .in_push_id(pid),
    .out_push_ready(ready), .out_request(req),
    .in_grant(gnt),
    .out_active_valid(act), .out_active_id(act_id),
    .out_done(done), .out_done_id(done_id),
    .out_preempt(pre), .out_grant_error(gerr)
  );

  request_agent #(
    .width(5), .time_quantum(2), .count_width(2)
  ) u_sat (
    .in_clk(clk), .in_reset(rst),
    .in_push_valid(s_pv), .in_push_id(s_pid),
    .out_push_ready(s_ready), .out_request(s_req),
    .in_grant(s_gnt),
    .out_active_valid(s_act), .out_active_id(s_act_id),
    .out_done(s_done), .out_done_id(s_done_id),
    .out_preempt(s_pre), .out_grant_error(s_gerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] id);
    pv = 1'b1;
    pid = id;
    tick();
    pv = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic serve2(input logic [4:0] g, input logic [2:0] id,
                        input logic [4:0] req_after, input string tag);
    gnt = g;
    tick();
    chk({tag, "_act"}, 32'(act), 32'd1);
    chk({tag, "_actid"}, 32'(act_id), 32'(id));
    tick();
    gnt = '0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_doneid"}, 32'(done_id), 32'(id));
    chk({tag, "_req"}, 32'(req), 32'(req_after));
  endtask

  initial begin
    rst = 1'b1;
    pv = 1'b0; pid = '0; gnt = '0;
    s_pv = 1'b0; s_pid = '0; s_gnt = '0;
    #12;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_act", 32'(act), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pre", 32'(pre), 32'd0);
    chk("rst_err", 32'(gerr), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single job on client 2
    push(3'd2);
    chk("t1_req", 32'(req), 32'h04);
    serve2(5'b00100, 3'd2, 5'b00000, "t1");
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // out-of-range push is never accepted
    pv = 1'b1; pid = 3'd5;
    #1;
    chk("oor_ready", 32'(ready), 32'd0);
    tick();
    pv = 1'b0;
    chk("oor_req", 32'(req), 32'd0);

    // 2: three jobs on client 2, one on client 3
    push(3'd2); push(3'd2); push(3'd2); push(3'd3);
    chk("t2_req0", 32'(req), 32'h0C);
    serve2(5'b00100, 3'd2, 5'b01100, "t2a");
    serve2(5'b01000, 3'd3, 5'b00100, "t2b");
    serve2(5'b00100, 3'd2, 5'b00100, "t2c");
    serve2(5'b00100, 3'd2, 5'b00000, "t2d");
    chk("t2_err", 32'(gerr), 32'd0);

    // 3: preemption of client 1
    push(3'd1);
    gnt = 5'b00010;
    tick();
    chk("t3_act", 32'(act), 32'd1);
    gnt = '0;
    tick();
    chk("t3_pre", 32'(pre), 32'd1);
    chk("t3_act_low", 32'(act), 32'd0);
    chk("t3_done_low", 32'(done), 32'd0);
    chk("t3_req", 32'(req), 32'h02);
    tick();
    chk("t3_pre_pulse", 32'(pre), 32'd0);
    serve2(5'b00010, 3'd1, 5'b00000, "t3r");
    chk("t3_err", 32'(gerr), 32'd0);

    // 4a: multi-bit grant
    push(3'd1); push(3'd3); push(3'd4);
    chk("t4_req", 32'(req), 32'h1A);
    gnt = 5'b11010;
    tick();
    gnt = '0;
    chk("t4_err_multi", 32'(gerr), 32'd1);
    chk("t4_noserve", 32'(act), 32'd0);
    tick(); tick();
    chk("t4_sticky", 32'(gerr), 32'd1);
    chk("t4_req_kept", 32'(req), 32'h1A);
    do_reset();
    chk("t4_clr", 32'(gerr), 32'd0);
    chk("t4_clr_req", 32'(req), 32'd0);

    // 4b: grant with no request
    gnt = 5'b00001;
    tick();
    gnt = '0;
    chk("t4_err_stray", 32'(gerr), 32'd1);
    chk("t4_stray_act", 32'(act), 32'd0);
    do_reset();
    chk("t4_clr2", 32'(gerr), 32'd0);

    // 5: saturation with 2-bit counters
    s_pv = 1'b1; s_pid = 3'd0;
    tick(); tick(); tick();
    #1;
    chk("t5_ready_full", 32'(s_ready), 32'd0);
    tick();
    s_pv = 1'b0;
    chk("t5_req", 32'(s_req), 32'h01);
    s_gnt = 5'b00001;
    tick();
    s_pv = 1'b1;
    #1;
    chk("t5_ready_noraise", 32'(s_ready), 32'd0);
    tick();
    s_pv = 1'b0;
    chk("t5_done1", 32'(s_done), 32'd1);
    chk("t5_ready_at2", 32'(s_ready), 32'd1);
    tick();
    s_pv = 1'b1;
    tick();
    s_pv = 1'b0;
    s_gnt = '0;
    chk("t5_done2", 32'(s_done), 32'd1);
    chk("t5_ready_net", 32'(s_ready), 32'd1);
    s_gnt = 5'b00001;
    tick(); tick();
    chk("t5_req_at1", 32'(s_req), 32'h01);
    tick(); tick();
    s_gnt = '0;
    chk("t5_req_empty", 32'(s_req), 32'h00);
    chk("t5_err", 32'(s_gerr), 32'd0);

    // 6: asynchronous reset mid-service
    push(3'd4);
    gnt = 5'b10000;
    tick();
    chk("t6_act", 32'(act), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_act0", 32'(act), 32'd0);
    chk("t6_req0", 32'(req), 32'd0);
    chk("t6_done0", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_done_held", 32'(done), 32'd0);
    @(negedge clk);
    gnt = '0;
    rst = 1'b0;
    tick();
    chk("t6_done_after", 32'(done), 32'd0);
    chk("t6_req_after", 32'(req), 32'd0);
    chk("t6_err", 32'(gerr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/request_agent.md
# request_agent

Client-side end of the round-robin arbiter's request/grant interface. Holds a per-client pending-job count for `width` clients and drives a one-hot-per-client `out_request` vector from those counts. It consumes the arbiter's `in_grant` vector and retires one job per client after `time_quantum` consecutive granted cycles. It also checks the grant vector for protocol violations. It sits opposite `round_robin` in the coprocessor and lets a real job source drive the arbiter.

## Interface
- `width`, 5: number of clients; request/grant vector width.
- `time_quantum`, 2: consecutive granted cycles needed to retire one job (≥1).
- `count_width`, 4: width of each pending-job counter; max pending per client = 2^count_width−1.
- `idx_w`, `$clog2(width)` (min 1): client index width; derived, not overridden.

- `in_clk` input 1: clock; all state updates on the rising edge.
- `in_reset` input 1: reset, asynchronous, active-high.
- `in_push_valid` input 1: push one job to client `in_push_id`.
- `in_push_id` input idx_w: target client of a push; values ≥ width are ignored (never accepted).
- `out_push_ready` output 1: combinational; high iff `in_push_id` < width and `pending[in_push_id]` < max.
- `out_request` output width: bit i high iff `pending[i]` ≠ 0 (decode of registers, no other logic).
- `in_grant` input width: arbiter grant vector.
- `out_active_valid` output 1: registered; high while in SERVE.
- `out_active_id` output idx_w: registered; client being served (0 when idle).
- `out_done` output 1: registered one-cycle pulse; a job retired.
- `out_done_id` output idx_w: registered; client of the retired job, valid with `out_done`.
- `out_preempt` output 1: registered one-cycle pulse; service aborted by grant loss.
- `out_grant_error` output 1: sticky error flag, cleared only by reset.

## Operation
- Push accepted when `in_push_valid` && `out_push_ready`; `pending[id]` += 1.
- FSM has two states.
  - IDLE: if `in_grant` is exactly one-hot on bit i and `pending[i]` ≠ 0 → SERVE, active_id = i, svc_cnt = 1. If `time_quantum` = 1, the job retires immediately instead and the FSM stays IDLE.
  - SERVE: if `in_grant` == one-hot(active_id), svc_cnt += 1. When svc_cnt reaches `time_quantum`: `pending[active_id]` −= 1, `out_done` pulses, FSM → IDLE.
  - SERVE, any other grant value: progress discarded, `out_preempt` pulses, → IDLE. The same cycle's grant is not re-evaluated for a new capture.
- Push and retire on the same client in the same cycle: net count unchanged.
- `out_push_ready` is computed from the current count only; a same-cycle retire does not raise it.
- Grant error: set on any cycle where `in_grant` has more than one bit set, or has a bit set whose `out_request` bit is low. Erroneous grants never start or continue service. An erroneous grant during SERVE counts as preemption.
- `in_grant` == 0 is legal and is not an error.
- svc_cnt is wide enough for `time_quantum`; it never wraps.
- Pending counters never over- or under-flow, by construction of ready/retire.
- Reset (asynchronous, any time including mid-service):
  - all pending = 0, FSM IDLE, svc_cnt = 0;
  - `out_request` = 0, `out_active_valid` = 0, `out_active_id` = 0;
  - `out_done` = 0, `out_done_id` = 0, `out_preempt` = 0, `out_grant_error` = 0;
  - an in-progress job is neither retired nor reported.

## Timing
- Push accepted in cycle t → `out_request[id]` high from cycle t+1.
- Service capture: the grant cycle g counts as service cycle 1. With `time_quantum` = Q and grant held on cycles g..g+Q−1:
  - `out_active_valid` is high during g+1..g+Q−1;
  - `out_done` is high in cycle g+Q;
  - the decremented pending count and any `out_request` drop are visible in g+Q.
- Back-to-back service of the same client: a new capture is possible in cycle g+Q if grant and pending still allow it.
- Preemption at cycle p (grant lost in SERVE) → `out_preempt` high in p+1, `out_active_valid` low in p+1; pending is unchanged.
- `out_grant_error` rises in the cycle after the offending grant and stays high.

## Test plan
1. Reset, then push client 2 once. Grant 5'b00100 for 2 cycles. Expect:
   - `out_request` = 00100 one cycle after the push;
   - `out_done` = 1 with `out_done_id` = 2;
   - `out_request` = 00000 in the same cycle as `out_done`.
2. Push client 2 ×3 and client 3 ×1. Alternate grants 00100 and 01000 every 2 cycles. Expect `out_done` ids in the order 2, 3, 2, 2, and `out_request` falling per client as its count empties.
3. Preempt: serve client 1 with Q = 2. Drop grant after 1 cycle. Expect:
   - `out_preempt` pulse;
   - `pending[1]` unchanged and `out_request[1]` still high;
   - a re-grant for 2 cycles then retires the job.
4. Errors:
   - grant 11010 → `out_grant_error` = 1 next cycle, no service;
   - separately, grant 00001 with request 00000 → error;
   - error stays set until `in_reset`.
5. Saturation: `count_width` = 2, push client 0 ×4. Expect the 4th push refused (`out_push_ready` = 0). A same-cycle push+retire on client 0 at count 2 leaves the count at 2.
6. Assert `in_reset` asynchronously mid-SERVE, between clock edges. Expect all outputs 0 immediately, no `out_done`, and `out_request` = 0 after release.
